// File: rtl/product_encoder.sv
// product_encoder: serially loads an N x N input tile and a K x K kernel, then
// emits, per input pixel in raster order, the K*K products pixel*weight on a
// valid/ready handshake for the transposed-convolution decoder to overlap-add.
//
// Latency: start sampled at edge t -> busy from t+1, first product set valid
//          from t+2; after each handshake the next set is valid two edges later.
// Backpressure: while prod_valid && !prod_ready every output is held stable;
//          prod_valid only drops after a handshake (or on reset).
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   load_kernel/load_input write data_in to the next kernel / tile slot (IDLE)
//   data_in                load data, PIXEL_WIDTH bits, unsigned
//   start                  begin product generation (honoured in IDLE only)
//   prod_ready             downstream accepts the current product set
//   prod_valid             multiplied_image / pixel_row / pixel_col are valid
//   multiplied_image       K*K products, product j=row*K+col at [j*OLEN +: OLEN]
//   pixel_row, pixel_col   coordinates of the source input pixel
//   last                   qualifies the final pixel (N-1, N-1)
//   busy                   high in every state except IDLE
//   encoding_complete      one-cycle pulse after the final handshake

module product_encoder #(
  parameter int N           = 2,
  parameter int K           = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int OLEN        = 2 * PIXEL_WIDTH,
  localparam int CW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_kernel,
  input  logic                    load_input,
  input  logic [PIXEL_WIDTH-1:0]  data_in,
  input  logic                    start,
  input  logic                    prod_ready,
  output logic                    prod_valid,
  output logic [K*K*OLEN-1:0]     multiplied_image,
  output logic [CW-1:0]           pixel_row,
  output logic [CW-1:0]           pixel_col,
  output logic                    last,
  output logic                    busy,
  output logic                    encoding_complete
);

  localparam int KK  = K * K;
  localparam int NP  = N * N;
  localparam int KIW = (KK > 1) ? $clog2(KK) : 1;
  localparam int PIW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_VALID = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Storage and indices
  logic [PIXEL_WIDTH-1:0] r_kernel [KK];
  logic [PIXEL_WIDTH-1:0] r_tile   [NP];
  logic [KIW-1:0]         r_kidx;
  logic [PIW-1:0]         r_iidx;
  logic [PIW-1:0]         r_p;

  // Registered outputs, updated only in CALC so they stay frozen in VALID
  logic [K*K*OLEN-1:0]    r_mult;
  logic [CW-1:0]          r_row;
  logic [CW-1:0]          r_col;

  logic                   w_hs;
  logic                   w_last_pix;
  logic [KIW-1:0]         w_kidx_nxt;
  logic [PIW-1:0]         w_iidx_nxt;
  logic [PIXEL_WIDTH-1:0] w_pix;

  assign w_last_pix = (r_p == PIW'(NP - 1));
  assign w_kidx_nxt = (r_kidx == KIW'(KK - 1)) ? '0 : r_kidx + KIW'(1);
  assign w_iidx_nxt = (r_iidx == PIW'(NP - 1)) ? '0 : r_iidx + PIW'(1);
  assign w_pix      = r_tile[r_p];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs. Control outputs come straight
  // from the state register so an asynchronous reset clears them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    prod_valid        = 1'b0;
    busy              = 1'b1;
    encoding_complete = 1'b0;
    w_hs              = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_state_nxt = S_VALID;
      end
      S_VALID: begin
        prod_valid = 1'b1;
        w_hs       = prod_ready;
        if (prod_ready) begin
          w_state_nxt = w_last_pix ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        encoding_complete = 1'b1;
        w_state_nxt       = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign last = prod_valid && w_last_pix;

  // ---------------------------------------------------------------------------
  // Datapath: loading, product generation and pixel sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KK; i++) begin
        r_kernel[i] <= '0;
      end
      for (int i = 0; i < NP; i++) begin
        r_tile[i] <= '0;
      end
      r_kidx <= '0;
      r_iidx <= '0;
      r_p    <= '0;
      r_mult <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Kernel wins a simultaneous load; the tile write is dropped and
          // its index is left where it was.
          if (load_kernel) begin
            r_kernel[r_kidx] <= data_in;
            r_kidx           <= w_kidx_nxt;
          end else if (load_input) begin
            r_tile[r_iidx] <= data_in;
            r_iidx         <= w_iidx_nxt;
          end
        end
        S_CALC: begin
          // Full-width unsigned products; OLEN is at least 2*PIXEL_WIDTH so
          // nothing is truncated.
          for (int j = 0; j < KK; j++) begin
            r_mult[j*OLEN +: OLEN] <= OLEN'(w_pix) * OLEN'(r_kernel[j]);
          end
          r_row <= CW'(int'(r_p) / N);
          r_col <= CW'(int'(r_p) % N);
        end
        S_VALID: begin
          // Advance only on a non-final handshake; the final pixel index is
          // kept so last stays asserted until DONE clears it.
          if (w_hs && !w_last_pix) begin
            r_p <= r_p + PIW'(1);
          end
        end
        S_DONE: begin
          // Indices rewind, stored data is kept so a new start replays it.
          r_p    <= '0;
          r_kidx <= '0;
          r_iidx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign multiplied_image = r_mult;
  assign pixel_row        = r_row;
  assign pixel_col        = r_col;

endmodule

// File: doc/product_encoder.md
# product_encoder

Front end of the transposed-convolution datapath, feeding the `decoder` stage. The block serially loads an N×N input tile and a K×K kernel, then walks the input pixels in raster order. For each input pixel it emits the K×K unsigned products (pixel × every kernel weight) on a valid/ready handshake. The decoder overlap-adds these products into the (N·K)×(N·K) output grid.

## Interface
- `N`, 2, input tile side; the tile has N×N pixels.
- `K`, 3, kernel side; the kernel has K×K weights.
- `PIXEL_WIDTH`, 8, width of input pixels and kernel weights (unsigned).
- `OLEN`, 2*PIXEL_WIDTH, product width; must equal the decoder `ILEN`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_kernel`  in  1  writes `data_in` into the next kernel slot.
- `load_input`  in  1  writes `data_in` into the next input-tile slot.
- `data_in`  in  PIXEL_WIDTH  load data.
- `start`  in  1  begins product generation (sampled in IDLE only).
- `prod_ready`  in  1  downstream accepts the current product set.
- `prod_valid`  out  1  `multiplied_image` and pixel coordinates are valid.
- `multiplied_image`  out  K*K*OLEN  product j = row·K+col, at bits [j*OLEN +: OLEN].
- `pixel_row`, `pixel_col`  out  max(1,$clog2(N))  coordinates of the source input pixel.
- `last`  out  1  high together with `prod_valid` for pixel (N-1,N-1).
- `busy`  out  1  high in every state except IDLE.
- `encoding_complete`  out  1  one-cycle pulse after the final handshake.

## Operation
- **States:**
  - IDLE → CALC on `start`.
  - CALC → VALID unconditionally.
  - VALID → CALC on a handshake, when the pixel is not the last one.
  - VALID → DONE on a handshake for the last pixel.
  - DONE → IDLE unconditionally.
- **Loading (IDLE only):**
  - `kidx` runs 0..K*K-1 and `iidx` runs 0..N*N-1, each wrapping to 0.
  - Each load-high cycle writes one slot and increments its index.
  - If `load_kernel` and `load_input` are both high, only the kernel write happens; the input write is dropped and `iidx` does not change.
  - Loads outside IDLE are ignored.
- **Start conditions:**
  - `start` with an incomplete load is legal; unloaded slots keep their previous or reset (0) value.
  - `start` while `busy` is ignored.
- **CALC:** registers `multiplied_image[j] = in[p] * kernel[j]` for all j, as a full-width unsigned OLEN product with no truncation or saturation. `p` is the raster pixel index 0..N*N-1.
- **Handshake:**
  - A handshake occurs on a cycle with `prod_valid && prod_ready`.
  - While `prod_valid && !prod_ready`, all outputs are held stable.
  - `prod_ready` is don't-care when `prod_valid` is low.
- **DONE:**
  - `encoding_complete` = 1 for exactly this cycle.
  - `p`, `kidx` and `iidx` clear to 0.
  - Stored kernel and tile data are kept, so re-running `start` reproduces the same stream.
- **Reset (`rst` low), at any time including mid-stream:**
  - The state goes to IDLE immediately.
  - All storage, indices and outputs clear to 0.

## Timing
- Reset values: `prod_valid`, `last`, `busy`, `encoding_complete` = 0; `multiplied_image`, `pixel_row`, `pixel_col` = 0.
- `start` sampled at edge t: `busy` = 1 from t+1 (CALC); `prod_valid` = 1 from t+2.
- Handshake at edge h:
  - `prod_valid` = 0 at h+1 (CALC).
  - `prod_valid` = 1 for the next pixel at h+2.
  - Peak throughput is therefore one pixel per 2 cycles.
- Final handshake at edge h: `encoding_complete` = 1 and `busy` = 1 during h+1 (DONE); `busy` = 0 from h+2.
- A `start` in the DONE cycle is ignored. The earliest restart is sampled at h+2.
- `prod_valid` never drops without a handshake, except on reset.

## Test plan
- **Reset values:** hold `rst` low, then release → all outputs 0, `busy` = 0.
- **Nominal stream:**
  - Stimulus: load kernel 1..9 and tile 2,3,4,5; pulse `start`; hold `prod_ready` = 1.
  - First `prod_valid` arrives 2 cycles after `start`, at (0,0) with products 2,4,…,18.
  - Exactly 4 handshakes occur; (1,1) carries products 5,10,…,45 with `last` = 1.
  - `encoding_complete` pulses once, 1 cycle after the last handshake.
- **Backpressure:** drop `prod_ready` for 5 cycles while pixel (0,1) is valid → `prod_valid` and products 3,6,…,27 stay constant; the stream resumes unchanged when `prod_ready` returns.
- **Width extremes:** all kernel and tile values 0xFF → every product is 0xFE01, with no overflow in the OLEN=16 field.
- **Load/start collisions:**
  - Assert `load_kernel` and `load_input` together with `data_in` = 7 → only kernel[0] becomes 7; `iidx` is unchanged.
  - Loads and `start` asserted while `busy` → storage and the stream are unaffected.
- **Reset mid-stream:**
  - Assert `rst` during pixel 2's VALID → outputs go to 0 immediately without waiting for a clock.
  - After release, `start` with no loads → 4 product sets, all zero, then `encoding_complete`.
